// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud divider helper and 8N1 defaults.
package uart_pkg;

  localparam int unsigned UartClkHz      = 100_000_000;
  localparam int unsigned UartBaudRate   = 115_200;
  localparam int unsigned UartOversample = 16;
  localparam int unsigned UartDataBits   = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } uart_rx_state_e;

  // Rounded clk_hz / (baud * os).
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud,
                                           input int unsigned os);
    longint unsigned den;
    den = longint'(baud) * longint'(os);
    return int'((longint'(clk_hz) + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Valid/ready byte stream from the UART receiver to its consumer.
interface uart_rx_if #(
  parameter int unsigned DataBits = 8
) ();
  logic                m_valid;
  logic                m_ready;
  logic [DataBits-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Oversample tick divider: one-cycle tick every Div clocks, synchronous clear for phase alignment.
module uart_baud_gen #(
  parameter int unsigned Div = 54
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || (cnt_q == CntLast)) cnt_d = '0;
  end

  assign tick_o = (cnt_q == CntLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampled mid-bit sampling, one-deep holding register on a
// valid/ready stream, and framing/overrun error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = UartClkHz,
  parameter int unsigned BAUD_RATE   = UartBaudRate,
  parameter int unsigned OVERSAMPLE  = UartOversample,
  parameter int unsigned DATA_BITS   = UartDataBits
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx,
  uart_rx_if.master m_if,
  output logic      frame_err,
  output logic      overrun,
  output logic      busy
);
  localparam int unsigned Div   = calc_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned TcntW = $clog2(OVERSAMPLE);
  localparam logic [TcntW-1:0] TcntHalf = TcntW'(OVERSAMPLE / 2 - 1);
  localparam logic [TcntW-1:0] TcntLast = TcntW'(OVERSAMPLE - 1);
  localparam logic [3:0]       BcntLast = 4'(DATA_BITS - 1);

  uart_rx_state_e       state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [TcntW-1:0]     tcnt_q, tcnt_d;
  logic [3:0]           bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 deliver_q, deliver_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 baud_clr, tick;

  uart_baud_gen #(
    .Div (Div)
  ) u_baud_gen (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (baud_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    bcnt_d      = bcnt_q;
    shreg_d     = shreg_q;
    baud_clr    = 1'b0;
    deliver_d   = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          baud_clr = 1'b1;
          tcnt_d   = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          if (tcnt_q == TcntHalf) begin
            if (rx_s_q) begin
              state_d = StIdle;
            end else begin
              tcnt_d  = '0;
              bcnt_d  = '0;
              state_d = StData;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (tcnt_q == TcntLast) begin
            tcnt_d  = '0;
            shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            bcnt_d  = bcnt_q + 1'b1;
            if (bcnt_q == BcntLast) state_d = StStop;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (tcnt_q == TcntLast) begin
            tcnt_d = '0;
            if (rx_s_q) begin
              deliver_d = 1'b1;
              state_d   = StIdle;
            end else begin
              frame_err_d = 1'b1;
              state_d     = StWaitIdle;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      StWaitIdle: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Holding register: a delivery landing on an unconsumed byte is dropped and flagged.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    overrun_d = 1'b0;
    if (valid_q && m_if.m_ready) valid_d = 1'b0;
    if (deliver_q) begin
      if (!valid_q || m_if.m_ready) begin
        valid_d = 1'b1;
        data_d  = shreg_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      tcnt_q      <= '0;
      bcnt_q      <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      tcnt_q      <= tcnt_d;
      bcnt_q      <= bcnt_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      deliver_q   <= deliver_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign m_if.m_valid = valid_q;
  assign m_if.m_data  = data_q;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != StIdle);
endmodule
